or_input_debouncer: RTL and testbench



---
 rtl/or_input_debouncer_pkg.sv | 14 +
 rtl/debounce_channel.sv | 123 ++++++++++++
 rtl/or_input_debouncer.sv | 31 +++
 tb/tb_or_input_debouncer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/or_input_debouncer_pkg.sv
// Shared types and constants for the OR-gate input debouncer.
// Edge pulses are built only with OR_INPUT_DEBOUNCER_EDGE_PULSE_EN.
package or_input_debouncer_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    COUNT_HI  = 2'd1,
    STABLE_HI = 2'd2,
    COUNT_LO  = 2'd3
  } deb_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One debounced line: 2-flop sync, stability counter FSM, edge pulses.
// Pulses are built only with OR_INPUT_DEBOUNCER_EDGE_PULSE_EN.
module debounce_channel
  import or_input_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic busy,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  deb_state_t       state;
  deb_state_t       state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             clean_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE_LO;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      clean <= clean_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clean_n = clean;
    unique case (state)
      STABLE_LO: begin
        if (s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_n = STABLE_HI;
            clean_n = 1'b1;
          end else begin
            state_n = COUNT_HI;
            cnt_n   = ONE;
          end
        end
      end
      COUNT_HI: begin
        if (!s2) begin
          state_n = STABLE_LO;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = STABLE_HI;
          cnt_n   = '0;
          clean_n = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      STABLE_HI: begin
        if (!s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_n = STABLE_LO;
            clean_n = 1'b0;
          end else begin
            state_n = COUNT_LO;
            cnt_n   = ONE;
          end
        end
      end
      COUNT_LO: begin
        if (s2) begin
          state_n = STABLE_HI;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = STABLE_LO;
          cnt_n   = '0;
          clean_n = 1'b0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
    endcase
  end

  assign busy = (state == COUNT_HI) || (state == COUNT_LO);

`ifdef OR_INPUT_DEBOUNCER_EDGE_PULSE_EN
  // Pulse rises with the clean_out change and drops one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= clean_n & ~clean;
      fall <= ~clean_n & clean;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/or_input_debouncer.sv
// Conditions the two raw lines feeding the OR gate's a/b inputs.
// Edge pulses are built only with OR_INPUT_DEBOUNCER_EDGE_PULSE_EN.
module or_input_debouncer
  import or_input_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] raw_in,
  output logic [1:0] clean_out,
  output logic [1:0] busy,
  output logic [1:0] rise_pulse,
  output logic [1:0] fall_pulse
);

  for (genvar i = 0; i < 2; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_in[i]),
      .clean (clean_out[i]),
      .busy  (busy[i]),
      .rise  (rise_pulse[i]),
      .fall  (fall_pulse[i])
    );
  end

endmodule

// File: tb/tb_or_input_debouncer.sv
// Scoreboard bench: DEBOUNCE_CYCLES=4 and =1 instances on shared raw lines.
module tb_or_input_debouncer;

  typedef struct {
    logic [1:0] clean;
    logic [1:0] busy;
    logic [1:0] rise;
    logic [1:0] fall;
  } obs_t;

`ifdef OR_INPUT_DEBOUNCER_EDGE_PULSE_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] raw = 2'b00;

  logic [1:0] clean4, busy4, rise4, fall4;
  logic [1:0] clean1, busy1, rise1, fall1;

  or_input_debouncer #(.DEBOUNCE_CYCLES(4)) u_d4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_in     (raw),
    .clean_out  (clean4),
    .busy       (busy4),
    .rise_pulse (rise4),
    .fall_pulse (fall4)
  );

  or_input_debouncer #(.DEBOUNCE_CYCLES(1)) u_d1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_in     (raw),
    .clean_out  (clean1),
    .busy       (busy1),
    .rise_pulse (rise1),
    .fall_pulse (fall1)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  obs_t exp_q[$];

  int         dc [2] = '{4, 1};
  logic [1:0] m_s1 [2];
  logic [1:0] m_s2 [2];
  logic [1:0] m_clean [2];
  logic [1:0] m_busy [2];
  logic [1:0] m_rise [2];
  logic [1:0] m_fall [2];
  int         m_run [2][2];

  int rc4 [2];
  int fc4 [2];
  int fe4 [2];
  int fe1 [2];
  int hi0_cnt;
  int busy0_seen;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_s1[u] = 2'b00;
      m_s2[u] = 2'b00;
      m_clean[u] = 2'b00;
      m_busy[u] = 2'b00;
      m_rise[u] = 2'b00;
      m_fall[u] = 2'b00;
      m_run[u][0] = 0;
      m_run[u][1] = 0;
    end
  endtask

  // Level accepted once the synced sample has differed from it D times in a row.
  task automatic model_step(input logic [1:0] r);
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < 2; c++) begin
        m_rise[u][c] = 1'b0;
        m_fall[u][c] = 1'b0;
        if (m_s2[u][c] != m_clean[u][c]) begin
          m_run[u][c]++;
          if (m_run[u][c] == dc[u]) begin
            m_clean[u][c] = m_s2[u][c];
            m_run[u][c] = 0;
            if (m_s2[u][c]) m_rise[u][c] = 1'b1;
            else m_fall[u][c] = 1'b1;
          end
        end else begin
          m_run[u][c] = 0;
        end
        m_busy[u][c] = (m_run[u][c] != 0);
      end
      m_s2[u] = m_s1[u];
      m_s1[u] = r;
    end
  endtask

  task automatic tick();
    obs_t e;
    obs_t g;
    if (rst_n) model_step(raw);
    for (int u = 0; u < 2; u++) begin
      e.clean = m_clean[u];
      e.busy = m_busy[u];
      e.rise = m_rise[u] & {2{PE}};
      e.fall = m_fall[u] & {2{PE}};
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      e = exp_q.pop_front();
      if (u == 0) g = '{clean4, busy4, rise4, fall4};
      else g = '{clean1, busy1, rise1, fall1};
      chk($sformatf("clean_u%0d", u), int'(g.clean), int'(e.clean));
      chk($sformatf("busy_u%0d", u), int'(g.busy), int'(e.busy));
      chk($sformatf("rise_u%0d", u), int'(g.rise), int'(e.rise));
      chk($sformatf("fall_u%0d", u), int'(g.fall), int'(e.fall));
    end
    for (int c = 0; c < 2; c++) begin
      rc4[c] += int'(rise4[c]);
      fc4[c] += int'(fall4[c]);
    end
    if (clean4[0]) hi0_cnt++;
    if (busy4[0]) busy0_seen = 1;
  endtask

  task automatic clr_counts();
    rc4 = '{0, 0};
    fc4 = '{0, 0};
    hi0_cnt = 0;
    busy0_seen = 0;
  endtask

  // First edge index (from 0) at which each channel reaches the target level.
  task automatic watch(input int n, input logic [1:0] tgt);
    fe4 = '{-1, -1};
    fe1 = '{-1, -1};
    for (int i = 0; i < n; i++) begin
      tick();
      for (int c = 0; c < 2; c++) begin
        if (fe4[c] < 0 && clean4[c] == tgt[c]) fe4[c] = i;
        if (fe1[c] < 0 && clean1[c] == tgt[c]) fe1[c] = i;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_d4"}, int'({clean4, busy4, rise4, fall4}), 0);
    chk({tag, "_d1"}, int'({clean1, busy1, rise1, fall1}), 0);
  endtask

  initial begin
    model_reset();
    clr_counts();

    // Held in reset with both lines high.
    raw = 2'b11;
    #2;
    chk_all_zero("reset_hold");
    for (int i = 0; i < 3; i++) tick();
    chk_all_zero("reset_hold_late");

    rst_n = 1'b1;
    clr_counts();
    watch(10, 2'b11);
    chk("rise_edge_d4", fe4[0], 5);
    chk("rise_edge_d4_b", fe4[1], 5);
    chk("rise_edge_d1", fe1[0], 2);
    chk("rise_pulses_0", rc4[0], int'(PE));
    chk("rise_pulses_1", rc4[1], int'(PE));

    // Falling edge on channel 0.
    clr_counts();
    raw = 2'b10;
    watch(10, 2'b10);
    chk("fall_edge_d4", fe4[0], 5);
    chk("fall_edge_d1", fe1[0], 2);
    chk("fall_pulses_0", fc4[0], int'(PE));
    chk("fall_pulses_1", fc4[1], 0);

    // Three-cycle glitch on channel 0 must be rejected at D=4.
    clr_counts();
    raw = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    raw = 2'b10;
    for (int i = 0; i < 8; i++) tick();
    chk("glitch_busy", busy0_seen, 1);
    chk("glitch_clean", hi0_cnt, 0);
    chk("glitch_rise", rc4[0], 0);

    // Independent channels, channel 1 two cycles ahead.
    raw = 2'b00;
    for (int i = 0; i < 8; i++) tick();
    clr_counts();
    raw = 2'b10;
    tick();
    tick();
    raw = 2'b11;
    watch(12, 2'b11);
    chk("indep_ch0", fe4[0], 5);
    chk("indep_gap", fe4[0] - fe4[1], 2);
    chk("indep_rise0", rc4[0], int'(PE));
    chk("indep_rise1", rc4[1], int'(PE));

    // Reset while channel counters sit at 2.
    raw = 2'b00;
    for (int i = 0; i < 8; i++) tick();
    raw = 2'b11;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_busy", int'(busy4), 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    clr_counts();
    watch(10, 2'b11);
    chk("rerun_d4", fe4[0], 5);
    chk("rerun_d1", fe1[1], 2);
    chk("rerun_rise", rc4[0], int'(PE));

    // Random hold lengths, checked by the scoreboard every edge.
    for (int k = 0; k < 60; k++) begin
      raw = 2'($urandom_range(0, 3));
      for (int i = 0; i < int'($urandom_range(1, 7)); i++) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
